// File: rtl/uart_pkg.sv
// Shared UART constants: default FIFO geometry and RX status-register bit positions.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef enum int unsigned {
    STAT_EMPTY_BIT  = 0,
    STAT_FULL_BIT   = 1,
    STAT_OVF_BIT    = 2,
    STAT_THRESH_BIT = 3
  } uart_rx_stat_bit_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX FWFT FIFO with sticky overflow; writes while full (no same-cycle pop) are dropped.
// Optional registered level flag enabled by UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  input  logic [ADDR_W:0]   thresh_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o,
  output logic              thresh_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              ovf;
  logic [DATA_W-1:0] head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wptr - rptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the slot being written, so a full FIFO still takes a write alongside it.
  assign wr_acc  = wr_en_i && (!full || rd_en_i);
  assign rd_acc  = rd_en_i && !empty;
  assign ovf_set = wr_en_i && full && !rd_en_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .wr_en   (wr_acc && !flush_i),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (wr_data_i),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (head)
  );

  assign rd_data_o = empty ? '0 : head;
  assign full_o    = full;
  assign empty_o   = empty;
  assign count_o   = count;
  assign ovf_o     = ovf;

`ifdef UART_RX_FIFO_THRESH_EN
  logic thresh_q;

  // Registered from the current level, so it trails count_o by one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      thresh_q <= 1'b0;
    end else if (flush_i) begin
      thresh_q <= 1'b0;
    end else begin
      thresh_q <= (thresh_i != '0) && (count >= thresh_i);
    end
  end

  assign thresh_o = thresh_q;
`else
  logic thresh_unused;

  assign thresh_unused = ^thresh_i;
  assign thresh_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue model checked every cycle, plus literal expectations.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_RX_FIFO_THRESH_EN
  localparam int THR_EN = 1;
`else
  localparam int THR_EN = 0;
`endif

  logic              clk_i;
  logic              rstn_i;
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_en_i;
  logic              flush_i;
  logic              ovf_clr_i;
  logic [ADDR_W:0]   thresh_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              ovf_o;
  logic              thresh_o;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .flush_i   (flush_i),
    .ovf_clr_i (ovf_clr_i),
    .thresh_i  (thresh_i),
    .rd_data_o (rd_data_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .count_o   (count_o),
    .ovf_o     (ovf_o),
    .thresh_o  (thresh_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored bytes plus the two flags.
  byte unsigned q[$];
  bit           m_ovf;
  bit           m_thr;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q.delete();
      m_ovf = 1'b0;
      m_thr = 1'b0;
    end else begin
      int lvl;
      lvl = q.size();
      m_thr = (THR_EN != 0) && (thresh_i != 0) && (lvl >= int'(thresh_i));
      if (flush_i) begin
        q.delete();
        m_ovf = 1'b0;
        m_thr = 1'b0;
      end else begin
        if (ovf_clr_i) m_ovf = 1'b0;
        if (wr_en_i && lvl == DEPTH && !rd_en_i) m_ovf = 1'b1;
        if (rd_en_i && lvl > 0) void'(q.pop_front());
        if (wr_en_i && (lvl < DEPTH || rd_en_i)) q.push_back(wr_data_i);
      end
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      chk("cmp count", int'(count_o), q.size());
      chk("cmp empty", int'(empty_o), int'(q.size() == 0));
      chk("cmp full", int'(full_o), int'(q.size() == DEPTH));
      chk("cmp rd_data", int'(rd_data_o), (q.size() != 0) ? int'(q[0]) : 0);
      chk("cmp ovf", int'(ovf_o), int'(m_ovf));
      chk("cmp thresh", int'(thresh_o), int'(m_thr));
    end
  end

  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit fl, input bit clr);
    @(negedge clk_i);
    #1;
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    flush_i   = fl;
    ovf_clr_i = clr;
    @(posedge clk_i);
    #1;
    wr_en_i   = 1'b0;
    wr_data_i = '0;
    rd_en_i   = 1'b0;
    flush_i   = 1'b0;
    ovf_clr_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn_i    = 1'b0;
    wr_en_i   = 1'b0;
    wr_data_i = '0;
    rd_en_i   = 1'b0;
    flush_i   = 1'b0;
    ovf_clr_i = 1'b0;
    thresh_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset empty", int'(empty_o), 1);
    chk("reset full", int'(full_o), 0);
    chk("reset count", int'(count_o), 0);
    chk("reset ovf", int'(ovf_o), 0);
    chk("reset thresh", int'(thresh_o), 0);
    chk("reset rd_data", int'(rd_data_o), 0);
    rstn_i = 1'b1;

    wr(8'hA5);
    chk("single data", int'(rd_data_o), 'hA5);
    chk("single empty", int'(empty_o), 0);
    chk("single count", int'(count_o), 1);
    pop();
    chk("single pop empty", int'(empty_o), 1);
    chk("single pop data", int'(rd_data_o), 0);

    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill full", int'(full_o), 1);
    chk("fill count", int'(count_o), 16);
    wr(8'hFF);
    chk("overflow ovf", int'(ovf_o), 1);
    chk("overflow count", int'(count_o), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", int'(rd_data_o), i);
      pop();
    end
    chk("drain empty", int'(empty_o), 1);
    chk("ovf still set", int'(ovf_o), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr alone", int'(ovf_o), 0);

    for (int i = 0; i < 16; i++) wr(8'(i));
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("full rw count", int'(count_o), 16);
    chk("full rw ovf", int'(ovf_o), 0);
    chk("full rw head", int'(rd_data_o), 'h01);
    for (int i = 1; i < 16; i++) begin
      chk("full rw order", int'(rd_data_o), i);
      pop();
    end
    chk("full rw last", int'(rd_data_o), 'h55);
    pop();
    chk("full rw drained", int'(empty_o), 1);

    for (int i = 0; i < 40; i++) begin
      wr(8'(i + 100));
      chk("pair data", int'(rd_data_o), i + 100);
      chk("pair level", int'(count_o <= 1), 1);
      pop();
    end
    pop();
    chk("pop empty count", int'(count_o), 0);
    chk("pop empty flag", int'(empty_o), 1);
    chk("pop empty ovf", int'(ovf_o), 0);

    for (int i = 0; i < 16; i++) wr(8'(i + 32));
    wr(8'hEE);
    repeat (11) pop();
    chk("pre-flush count", int'(count_o), 5);
    chk("pre-flush ovf", int'(ovf_o), 1);
    chk("pre-flush head", int'(rd_data_o), 43);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("flush count", int'(count_o), 0);
    chk("flush empty", int'(empty_o), 1);
    chk("flush ovf", int'(ovf_o), 0);
    idle();
    chk("flush write dropped", int'(count_o), 0);

    thresh_i = 5'd4;
    for (int i = 0; i < 4; i++) wr(8'(i + 200));
    chk("thresh lag", int'(thresh_o), 0);
    idle();
    chk("thresh rise", int'(thresh_o), THR_EN);
    pop();
    chk("thresh at 3 count", int'(count_o), 3);
    chk("thresh hold", int'(thresh_o), THR_EN);
    idle();
    chk("thresh fall", int'(thresh_o), 0);
    thresh_i = 5'd0;
    wr(8'hC3);
    idle();
    chk("thresh zero", int'(thresh_o), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    #3;
    rstn_i = 1'b0;
    #1;
    chk("async rst empty", int'(empty_o), 1);
    chk("async rst count", int'(count_o), 0);
    chk("async rst data", int'(rd_data_o), 0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    wr(8'h44);
    chk("post rst data", int'(rd_data_o), 'h44);
    chk("post rst count", int'(count_o), 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side FIFO between the UART receiver and the APB register block. It captures one byte per single-cycle write strobe from the receiver and presents the oldest byte first-word-fall-through to the APB RX data register. It reports `full` back to the receiver for overrun detection, and reports `empty`, level, sticky overflow and an optional threshold flag to the status/interrupt logic. It is fully synchronous to `clk_i`.

## Interface
Parameters:
- DATA_W, 8, byte width
- DEPTH, 16, number of entries; power of two, at least 2
- ADDR_W, $clog2(DEPTH), memory index width (derived)

Ports:
- clk_i  in  1  system/APB clock
- rstn_i  in  1  asynchronous, active-low reset
- wr_en_i  in  1  one-cycle write strobe from the receiver
- wr_data_i  in  DATA_W  received byte, valid with wr_en_i
- rd_en_i  in  1  one-cycle pop strobe from the APB read of the RX data register
- flush_i  in  1  synchronous flush from the control register
- ovf_clr_i  in  1  clears the sticky overflow flag
- thresh_i  in  ADDR_W+1  interrupt level; used only with UART_RX_FIFO_THRESH_EN
- rd_data_o  out  DATA_W  head byte; 0 when empty
- full_o  out  1  count == DEPTH; drives the receiver full input
- empty_o  out  1  count == 0
- count_o  out  ADDR_W+1  current fill level, 0..DEPTH
- ovf_o  out  1  sticky flag: a write was dropped
- thresh_o  out  1  level at or above threshold

## Operation
- Write and read pointers are ADDR_W+1 bits wide. Both wrap modulo 2·DEPTH, and the memory index is ptr[ADDR_W-1:0].
- count_o = wptr − rptr, computed modulo 2^(ADDR_W+1).
- full_o = (count_o == DEPTH). empty_o = (count_o == 0). Both flags are derived combinationally from the pointer registers only.
- Write accepted when wr_en_i && (!full_o || rd_en_i):
  - mem[wptr] <= wr_data_i.
  - wptr increments.
- Read accepted when rd_en_i && !empty_o: rptr increments. A read while empty is ignored, with no state change.
- A write while full without a simultaneous read is dropped and sets ovf_o. Memory and pointers are untouched.
- Simultaneous read and write:
  - When full: both are accepted, count stays DEPTH, and ovf_o is not set.
  - When empty: the write is accepted, the read is ignored, and count becomes 1.
- flush_i has highest priority:
  - rptr <= wptr <= 0 and ovf_o <= 0.
  - A same-cycle write or read is discarded, and ovf_o is not set.
- ovf_o clears on ovf_clr_i, flush_i or reset. If a set and ovf_clr_i occur in the same cycle, the set wins.
- rd_data_o = empty_o ? 0 : mem[rptr index], read combinationally (FWFT).

## Timing
- Reset values:
  - Pointers 0.
  - empty_o = 1, full_o = 0, count_o = 0.
  - ovf_o = 0, thresh_o = 0, rd_data_o = 0.
  - Memory contents are not reset.
- Write to read visibility: a byte written in cycle N appears on rd_data_o, with empty_o low, in cycle N+1.
- A pop in cycle N presents the next byte (or 0/empty) in cycle N+1.
- full_o asserts in the cycle after the DEPTH-th accepted write. The receiver samples it in its own domain and treats it as quasi-static.
- The receiver's strobe is exactly one clk_i cycle. Back-to-back write strobes on consecutive cycles are supported.
- An asynchronous reset mid-operation empties the FIFO immediately. No partial write survives.

## Configuration
- UART_RX_FIFO_THRESH_EN defined:
  - thresh_o is a register updated each cycle to (thresh_i != 0) && (count_o >= thresh_i). It therefore lags count_o by one cycle.
  - flush_i and reset clear it.
- Undefined: thresh_i is ignored and thresh_o is tied 0.

## Structure
- Package `uart_pkg` holds:
  - UART_DATA_W = 8.
  - UART_RX_FIFO_DEPTH = 16.
  - Status-register bit indices for empty, full, ovf and thresh.
- One sub-module, `uart_fifo_mem`: DEPTH×DATA_W storage with a synchronous write port and an asynchronous read port, and no reset. Pointer, flag and overflow logic stay in uart_rx_fifo.

## Test plan
- Reset, then write 0xA5 → next cycle rd_data_o = 0xA5, empty_o = 0, count_o = 1. Pop → empty_o = 1, rd_data_o = 0.
- Write 16 bytes 0x00..0x0F → full_o = 1, count_o = 16. A 17th write of 0xFF → ovf_o = 1, and pops return 0x00..0x0F in order with no 0xFF.
- Fill to 16, then pulse rd_en_i and wr_en_i (0x55) in the same cycle → count_o stays 16, ovf_o = 0, head becomes 0x01, and 0x55 is read last.
- Perform 40 write/pop pairs across the pointer wrap → data order is preserved and count_o never exceeds 1. A pop while empty → no change.
- With 5 entries and ovf_o = 1, assert flush_i together with wr_en_i → count_o = 0, empty_o = 1, ovf_o = 0, write discarded. Separately, ovf_clr_i alone clears ovf_o.
- With UART_RX_FIFO_THRESH_EN and thresh_i = 4:
  - thresh_o rises the cycle after the 4th write and falls the cycle after the pop to 3.
  - thresh_i = 0 keeps it 0.
  - Without the macro, thresh_o stays 0.
